// File: rtl/cpu_pkg.sv
//==============================================================================
// Module : cpu_pkg
// Desc   : Shared condition-code encodings, flag-mask layout and branch FSM
//          state type for the 16-bit pipelined CPU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] CC_NE   = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GTE  = 3'b100;
    localparam logic [2:0] CC_LTE  = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;
    localparam logic [2:0] CC_UNC  = 3'b111;

    // Bit positions inside a 3-bit {Z,V,N} flag mask
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } br_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/cond_eval.sv
//==============================================================================
// Module : cond_eval
// Desc   : Combinational condition evaluator: branch-taken decision and the
//          mask of flags the condition depends on.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic       flag_n,
    output logic       taken,
    output logic [2:0] need
);

    always_comb begin
        taken = 1'b0;
        need  = 3'b000;
        case (ccc)
            CC_NE: begin
                taken        = ~flag_z;
                need[FLAG_Z] = 1'b1;
            end
            CC_EQ: begin
                taken        = flag_z;
                need[FLAG_Z] = 1'b1;
            end
            CC_GT: begin
                taken        = ~flag_z & ~flag_n;
                need[FLAG_Z] = 1'b1;
                need[FLAG_N] = 1'b1;
            end
            CC_LT: begin
                taken        = flag_n;
                need[FLAG_N] = 1'b1;
            end
            CC_GTE: begin
                taken        = flag_z | ~flag_n;
                need[FLAG_Z] = 1'b1;
                need[FLAG_N] = 1'b1;
            end
            CC_LTE: begin
                taken        = flag_n | flag_z;
                need[FLAG_Z] = 1'b1;
                need[FLAG_N] = 1'b1;
            end
            CC_OVFL: begin
                taken        = flag_v;
                need[FLAG_V] = 1'b1;
            end
            default: begin
                taken = 1'b1;
            end
        endcase
    end

endmodule : cond_eval

`default_nettype wire

// File: rtl/branch_unit.sv
//==============================================================================
// Module : branch_unit
// Desc   : Decode-stage branch resolver with flag-hazard stall, registered
//          redirect to fetch and saturating branch statistics.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module branch_unit
    import cpu_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_b,
    input  logic             id_is_br,
    input  logic [2:0]       id_ccc,
    input  logic [W-1:0]     id_pc_plus2,
    input  logic [8:0]       id_imm9,
    input  logic [W-1:0]     id_rs_data,
    input  logic             ex_wr_z,
    input  logic             ex_wr_v,
    input  logic             ex_wr_n,
    input  logic             flag_z,
    input  logic             flag_v,
    input  logic             flag_n,
    input  logic             stats_clr,
    output logic             stall,
    output logic             redirect,
    output logic [W-1:0]     redirect_pc,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    br_state_t        r_state;
    br_state_t        w_next_state;
    logic             r_redirect;
    logic [W-1:0]     r_redirect_pc;
    logic [CNT_W-1:0] r_br_total;
    logic [CNT_W-1:0] r_br_taken;

    logic             w_br_present;
    logic             w_hazard;
    logic             w_stall;
    logic             w_resolve;
    logic             w_taken;
    logic [2:0]       w_need;
    logic [W-1:0]     w_b_offset;
    logic [W-1:0]     w_target;

    cond_eval u_cond_eval (
        .ccc    (id_ccc),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n),
        .taken  (w_taken),
        .need   (w_need)
    );

    // The instruction sitting in decode while redirect is high is wrong-path
    assign w_br_present = id_valid & (id_is_b | id_is_br) & ~r_redirect;
    assign w_hazard     = w_br_present & (|(w_need & {ex_wr_z, ex_wr_v, ex_wr_n}));

    // Word offset scaled to bytes, sign-extended to W bits
    assign w_b_offset = {{(W-10){id_imm9[8]}}, id_imm9, 1'b0};
    assign w_target   = id_is_br ? id_rs_data : (id_pc_plus2 + w_b_offset);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // WAIT resolves unconditionally: the stall cycle put a bubble into EX,
    // so the flag register is now up to date.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_resolve    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_br_present) begin
                    if (w_hazard) begin
                        w_stall      = 1'b1;
                        w_next_state = WAIT;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_resolve    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_resolve & w_taken;
            if (w_resolve & w_taken) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_total <= '0;
            r_br_taken <= '0;
        end else if (stats_clr) begin
            r_br_total <= '0;
            r_br_taken <= '0;
        end else if (w_resolve) begin
            if (r_br_total != c_cnt_max) begin
                r_br_total <= r_br_total + c_cnt_one;
            end
            if (w_taken && (r_br_taken != c_cnt_max)) begin
                r_br_taken <= r_br_taken + c_cnt_one;
            end
        end
    end

    assign stall       = w_stall & rst_n;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign br_total    = r_br_total;
    assign br_taken    = r_br_taken;

endmodule : branch_unit

`default_nettype wire

// File: tb/tb_branch_unit.sv
//==============================================================================
// Module : tb_branch_unit
// Desc   : Scoreboard bench for branch_unit with directed and random branches.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_branch_unit;

    localparam int W     = 16;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, id_is_b, id_is_br;
    logic [2:0]       id_ccc;
    logic [W-1:0]     id_pc_plus2, id_rs_data;
    logic [8:0]       id_imm9;
    logic             ex_wr_z, ex_wr_v, ex_wr_n;
    logic             flag_z, flag_v, flag_n;
    logic             stats_clr;
    logic             stall, redirect;
    logic [W-1:0]     redirect_pc;
    logic [CNT_W-1:0] br_total, br_taken;

    branch_unit #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_is_b     (id_is_b),
        .id_is_br    (id_is_br),
        .id_ccc      (id_ccc),
        .id_pc_plus2 (id_pc_plus2),
        .id_imm9     (id_imm9),
        .id_rs_data  (id_rs_data),
        .ex_wr_z     (ex_wr_z),
        .ex_wr_v     (ex_wr_v),
        .ex_wr_n     (ex_wr_n),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .flag_n      (flag_n),
        .stats_clr   (stats_clr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .br_total    (br_total),
        .br_taken    (br_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pc;
        int           tot;
        int           tk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_total  = 0;
    int   m_taken  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition table: ccc -> taken
    function automatic bit f_taken(input logic [2:0] c, input logic [2:0] zvn);
        bit z, v, n;
        z = zvn[2]; v = zvn[1]; n = zvn[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    // Flags read by each condition, as a {Z,V,N} mask
    function automatic logic [2:0] f_need(input logic [2:0] c);
        case (c)
            3'd0, 3'd1:       return 3'b100;
            3'd2, 3'd4, 3'd5: return 3'b101;
            3'd3:             return 3'b001;
            3'd6:             return 3'b010;
            default:          return 3'b000;
        endcase
    endfunction

    // Monitor: every redirect pulse must match the oldest expected taken branch
    always @(negedge clk) begin
        if (redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("redirect_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                chk("redirect_total", 32'(br_total), 32'(e.tot));
                chk("redirect_taken", 32'(br_taken), 32'(e.tk));
            end
        end
    end

    // One branch transaction: issue, optional hazard stall, resolve, check
    task automatic do_branch(input bit is_br, input logic [2:0] c, input logic [W-1:0] pc2,
                             input logic [8:0] imm, input logic [W-1:0] rs,
                             input logic [2:0] exw, input logic [2:0] fl,
                             input logic [2:0] fl2, input bit clr, input bit wp);
        bit           hz, t;
        logic [2:0]   fu;
        logic [W-1:0] tgt;
        int           off;
        @(posedge clk); #1;
        id_valid = 1'b1; id_is_b = !is_br; id_is_br = is_br;
        id_ccc = c; id_pc_plus2 = pc2; id_imm9 = imm; id_rs_data = rs;
        {ex_wr_z, ex_wr_v, ex_wr_n} = exw;
        {flag_z, flag_v, flag_n} = fl;
        hz = |(f_need(c) & exw);
        fu = fl;
        if (hz) begin
            @(negedge clk);
            chk("stall_hazard", 32'(stall), 32'd1);
            @(posedge clk); #1;
            {flag_z, flag_v, flag_n} = fl2;
            {ex_wr_z, ex_wr_v, ex_wr_n} = 3'b000;
            fu = fl2;
        end
        stats_clr = clr;
        @(negedge clk);
        chk("stall_resolve", 32'(stall), 32'd0);
        t   = f_taken(c, fu);
        off = imm[8] ? int'(imm) - 512 : int'(imm);
        tgt = is_br ? rs : W'(int'(pc2) + 2 * off);
        if (clr) begin
            m_total = 0;
            m_taken = 0;
        end else begin
            if (m_total < MAXC) m_total++;
            if (t && m_taken < MAXC) m_taken++;
        end
        if (t) exp_q.push_back('{pc: tgt, tot: m_total, tk: m_taken});
        @(posedge clk); #1;
        stats_clr = 1'b0;
        if (t && wp) begin
            // Wrong-path branch in decode while redirect is high
            id_ccc = 3'($urandom);
            {ex_wr_z, ex_wr_v, ex_wr_n} = 3'b111;
        end else begin
            id_valid = 1'b0;
            {ex_wr_z, ex_wr_v, ex_wr_n} = 3'($urandom);
        end
        @(negedge clk);
        chk("stall_after", 32'(stall), 32'd0);
        chk("redirect_level", 32'(redirect), 32'(t));
        chk("br_total", 32'(br_total), 32'(m_total));
        chk("br_taken", 32'(br_taken), 32'(m_taken));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            id_valid = 1'b0;
            id_is_b  = 1'($urandom);
            id_is_br = !id_is_b;
            {ex_wr_z, ex_wr_v, ex_wr_n} = 3'($urandom);
            @(negedge clk);
            chk("stall_idle", 32'(stall), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stats_clr = 1'b0;
        id_valid = 1'b1; id_is_b = 1'b1; id_is_br = 1'b0; id_ccc = 3'd1;
        id_pc_plus2 = '0; id_imm9 = '0; id_rs_data = '0;
        ex_wr_z = 1'b1; ex_wr_v = 1'b0; ex_wr_n = 1'b0;
        flag_z = 1'b1; flag_v = 1'b0; flag_n = 1'b0;

        // Reset values; a hazarding branch must not raise stall in reset
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        chk("rst_total", 32'(br_total), 32'd0);
        chk("rst_taken", 32'(br_taken), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; id_valid = 1'b0; ex_wr_z = 1'b0;

        // Reset while waiting on a hazard: no redirect, no count
        @(posedge clk); #1;
        id_valid = 1'b1; id_is_b = 1'b1; id_ccc = 3'd1; ex_wr_z = 1'b1; flag_z = 1'b1;
        @(negedge clk);
        chk("midwait_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midwait_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; id_valid = 1'b0; ex_wr_z = 1'b0;
        @(negedge clk);
        chk("midwait_total", 32'(br_total), 32'd0);
        chk("midwait_taken", 32'(br_taken), 32'd0);
        idle(3);

        // Directed cases
        do_branch(0, 3'd1, 16'h0010, 9'h1FE, 16'h0, 3'b000, 3'b100, 3'b000, 0, 0); // EQ -> 0x000C
        do_branch(0, 3'd2, 16'h1234, 9'h005, 16'h0, 3'b001, 3'b100, 3'b000, 0, 1); // GT after stall
        do_branch(0, 3'd6, 16'h0200, 9'h010, 16'h0, 3'b101, 3'b000, 3'b000, 0, 0); // OVFL not taken
        do_branch(1, 3'd7, 16'h0040, 9'h000, 16'hFFFE, 3'b111, 3'b000, 3'b000, 0, 1); // BR UNC
        do_branch(0, 3'd7, 16'hFFFE, 9'h002, 16'h0, 3'b000, 3'b000, 3'b000, 0, 0); // wraps to 0x0002
        do_branch(0, 3'd3, 16'h0100, 9'h100, 16'h0, 3'b011, 3'b000, 3'b001, 0, 1); // LT, min offset
        idle(2);

        // Random branches
        for (int i = 0; i < 60; i++) begin
            do_branch(1'($urandom), 3'($urandom), 16'($urandom), 9'($urandom), 16'($urandom),
                      3'($urandom), 3'($urandom), 3'($urandom),
                      ($urandom_range(15) == 0), 1'($urandom));
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end

        // Saturation: clear, fill to max, one more, then clear on a resolve
        do_branch(0, 3'd7, 16'h0008, 9'h001, 16'h0, 3'b000, 3'b000, 3'b000, 1, 0);
        for (int i = 0; i < 15; i++)
            do_branch(0, 3'd7, 16'h0008, 9'h001, 16'h0, 3'b000, 3'b000, 3'b000, 0, 0);
        do_branch(0, 3'd7, 16'h0030, 9'h0FF, 16'h0, 3'b111, 3'b000, 3'b000, 0, 0);
        do_branch(0, 3'd1, 16'h0050, 9'h004, 16'h0, 3'b000, 3'b100, 3'b000, 1, 0);
        idle(3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_branch_unit

`default_nettype wire
